mem2_load_queue: RTL and testbench
==================================

# mem2_load_queue

Parametrised second memory stage. It holds up to DEPTH in-order load instructions whose data-SRAM requests are already issued. It captures `data_ok` responses in request order, byte-aligns and sign/zero-extends the data, and presents completed loads to writeback through a valid/ready handshake. Compared with a single-slot mem2 stage, it can absorb back-to-back responses while writeback stalls. It also discards responses still outstanding after a pipeline flush.

## Interface
Parameters:
- DEPTH, 4, maximum outstanding loads; power of two, ≥2
- DEST_W, 5, destination register index width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  exception/eret flush; drops all queued loads
- in_valid  in  1  new issued load from mem1
- in_ready  out  1  slot available (count < DEPTH)
- in_op  in  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lwl, 6 lwr, 7 reserved (treated as lw)
- in_low_addr  in  2  address bits [1:0]
- in_dest  in  DEST_W  destination register
- in_rt_old  in  32  current rt value (lwl/lwr merge)
- in_pc  in  32  instruction PC
- data_sram_data_ok  in  1  one response, in request order
- data_sram_rdata  in  32  response data
- out_valid  out  1  head load complete
- out_ready  in  1  writeback accepts
- out_dest  out  DEST_W  destination
- out_wdata  out  32  aligned result
- out_rf_wen  out  4  byte write enables
- out_pc  out  32  PC of head entry
- pending  out  $clog2(DEPTH)+1  occupied entries
- proto_err  out  1  sticky: unexpected data_ok received

## Operation
- Circular entry array: {op, low_addr, dest, rt_old, pc, rdata, done}. Three pointers:
  - tail (allocate)
  - resp (next entry awaiting data)
  - head (retire)
- Allocate: in_valid && in_ready && !flush → write entry at tail; done=0; tail++.
- Response: data_sram_data_ok routing:
  - discard_cnt>0 → discard_cnt--, data dropped.
  - else if resp != tail → rdata stored, done=1, resp++.
  - else → proto_err set.
- Retire: out_valid && out_ready && !flush → head++. out_valid = entry[head].done && pending>0.
- Extension from rdata and low_addr (a):
  - lb/lbu select byte a; lh/lhu select halfword a[1]; lw uses the word.
  - Sign/zero-extend per op.
  - lh/lhu with a[0]=1 is never enqueued; this is mem1's address-error check.
- lwl (a): data = rdata << 8·(3−a); rf_wen is 1000, 1100, 1110, 1111 for a = 0..3.
- lwr (a): data = rdata >> 8·a; rf_wen is 1111, 0111, 0011, 0001 for a = 0..3.
- All other ops: rf_wen = 1111.
- flush:
  - head = resp = tail = 0.
  - discard_cnt += (entries with done=0), counted before the flush edge.
  - A data_ok arriving in the flush cycle is counted as belonging to one of those entries.
  - in_valid is ignored in the flush cycle.
- in_ready during flush cycle follows the pre-flush count. discard_cnt width is $clog2(DEPTH)+1 and saturates at DEPTH.

## Timing
- Reset values:
  - pointers 0; discard_cnt 0; all done bits 0; proto_err 0.
  - pending 0, out_valid 0, in_ready 1.
  - out_dest/out_wdata/out_rf_wen/out_pc 0.
- data_ok in cycle N → out_valid earliest in cycle N+1, because rdata is registered. No combinational path from data_sram_rdata to outputs.
- Allocate in cycle N with data_ok in the same cycle → the response goes to the oldest unfilled entry, never the new one.
- Full (pending==DEPTH): in_ready=0. A retire in the same cycle does not raise in_ready until the next cycle.
- Simultaneous allocate and retire keeps pending constant.
- out_* is stable while out_valid && !out_ready.
- Reset mid-operation clears everything immediately. Outstanding bus responses after reset are the bus's responsibility.

## Configuration
- LWLR_MERGE_EN defined:
  - lwl/lwr out_wdata merges in_rt_old into the unwritten bytes.
  - out_rf_wen = 1111 for every load.
- LWLR_MERGE_EN undefined:
  - unwritten bytes are 0 and out_rf_wen carries the partial mask.
  - rt_old is not stored; the field is removed from the entry.

## Test plan
- Single lb, a=3, rdata 0x80AB_CDEF, out_ready=1 → next cycle out_wdata 0xFFFF_FF80, rf_wen 1111; pending returns to 0.
- Four lhu back-to-back (a=2, rdata 0x1234_5678 each), out_ready=0 → in_ready=0 after the 4th; release → four outputs of 0x0000_1234 on consecutive cycles.
- lwl a=1, rdata 0xAABB_CCDD, rt_old 0x1122_3344:
  - with LWLR_MERGE_EN: 0xCCDD_3344, rf_wen 1111.
  - without: 0xCCDD_0000, rf_wen 1100.
- lwr a=2, rdata 0xAABB_CCDD, rt_old 0x1122_3344:
  - with LWLR_MERGE_EN: 0x1122_AABB, rf_wen 1111.
  - without: 0x0000_AABB, rf_wen 0011.
- Three loads issued, one answered, then flush in the same cycle as the 2nd data_ok:
  - next two data_ok are dropped; no out_valid; proto_err 0.
  - a new load is then accepted, and its data appears correctly.
- data_ok with pending=0 and no discards → proto_err=1 and stays set until reset; no out_valid.

Source files
------------

// File: rtl/mem2_load_queue_if.sv
// Handshake/bus bundle for mem2_load_queue: mem1 issue side, data-SRAM
// response side, writeback side and status.
// The slave modport is the queue; the master modport is its environment.
interface mem2_load_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DEST_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [1:0]        in_low_addr;
  logic [DEST_W-1:0] in_dest;
  logic [31:0]       in_rt_old;
  logic [31:0]       in_pc;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DEST_W-1:0] out_dest;
  logic [31:0]       out_wdata;
  logic [3:0]        out_rf_wen;
  logic [31:0]       out_pc;
  logic [CNT_W-1:0]  pending;
  logic              proto_err;

  modport master (
    output flush, in_valid, in_op, in_low_addr, in_dest, in_rt_old, in_pc,
    output data_sram_data_ok, data_sram_rdata, out_ready,
    input  in_ready, out_valid, out_dest, out_wdata, out_rf_wen, out_pc,
    input  pending, proto_err
  );

  modport slave (
    input  flush, in_valid, in_op, in_low_addr, in_dest, in_rt_old, in_pc,
    input  data_sram_data_ok, data_sram_rdata, out_ready,
    output in_ready, out_valid, out_dest, out_wdata, out_rf_wen, out_pc,
    output pending, proto_err
  );
endinterface

// File: rtl/mem2_load_queue.sv
// Second memory stage as an in-order load queue of DEPTH entries.
// Loads are allocated at tail, filled with data_ok responses in request order
// at resp, and retired to writeback from head once filled. Responses that
// belong to loads killed by a flush are counted and dropped.
// Optional feature macro: LWLR_MERGE_EN (lwl/lwr merge rt_old into the
// unwritten bytes and always write all four bytes).
module mem2_load_queue #(
  parameter int DEPTH  = 4,
  parameter int DEST_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  mem2_load_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage (data only, never reset)
  logic [2:0]        op_q    [DEPTH];
  logic [1:0]        addr_q  [DEPTH];
  logic [DEST_W-1:0] dest_q  [DEPTH];
  logic [31:0]       pc_q    [DEPTH];
  logic [31:0]       rdata_q [DEPTH];
`ifdef LWLR_MERGE_EN
  logic [31:0]       rt_old_q [DEPTH];
`endif

  // Control state
  logic [DEPTH-1:0] done_q;
  logic [PTR_W-1:0] head_q, resp_q, tail_q;
  logic [CNT_W-1:0] count_q;     // occupied entries
  logic [CNT_W-1:0] unfilled_q;  // occupied entries still waiting for data
  logic [CNT_W-1:0] discard_q;   // responses owed to flushed loads
  logic             proto_err_q;

  logic             alloc, retire, out_vld;
  logic             rsp_discard, rsp_fill, rsp_orphan;
  logic             orphan_flush;
  logic [CNT_W:0]   disc_sum;
  logic [CNT_W-1:0] disc_flush;
  logic [35:0]      ext;

  // Byte-align and extend one load result; returns {rf_wen, wdata}.
  // lwl/lwr shifts use ~a == 3-a for a 2-bit offset.
`ifdef LWLR_MERGE_EN
  function automatic logic [35:0] extend_load(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] rdata, input logic [31:0] rt_old);
`else
  function automatic logic [35:0] extend_load(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] rdata);
`endif
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        data;
    logic [3:0]         wen;
`ifdef LWLR_MERGE_EN
    logic [31:0]        mask;
`endif
    b    = rdata[{a, 3'b000} +: 8];
    h    = a[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    wen  = 4'b1111;
    case (op)
      3'd1:    data = 32'(b);
      3'd2:    data = {24'b0, b};
      3'd3:    data = 32'(h);
      3'd4:    data = {16'b0, h};
      3'd5: begin
        data = rdata << {~a, 3'b000};
        wen  = 4'b1111 << ~a;
      end
      3'd6: begin
        data = rdata >> {a, 3'b000};
        wen  = 4'b1111 >> a;
      end
      default: data = rdata;
    endcase
`ifdef LWLR_MERGE_EN
    mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    data = (data & mask) | (rt_old & ~mask);
    wen  = 4'b1111;
`endif
    return {wen, data};
  endfunction

  // Handshakes, response routing and flush discard accounting
  always_comb begin
    bus.in_ready = count_q < CNT_W'(DEPTH);
    alloc        = bus.in_valid && bus.in_ready && !bus.flush;
    out_vld      = done_q[head_q] && (count_q != '0);
    retire       = out_vld && bus.out_ready && !bus.flush;

    rsp_discard  = bus.data_sram_data_ok && !bus.flush && (discard_q != '0);
    rsp_fill     = bus.data_sram_data_ok && !bus.flush && (discard_q == '0) && (unfilled_q != '0);
    rsp_orphan   = bus.data_sram_data_ok && !bus.flush && (discard_q == '0) && (unfilled_q == '0);

    // On flush every still-unfilled entry will produce a response to drop;
    // a data_ok in the flush cycle itself consumes one of those.
    disc_sum     = {1'b0, discard_q} + {1'b0, unfilled_q};
    orphan_flush = 1'b0;
    if (bus.data_sram_data_ok) begin
      if (disc_sum != '0) disc_sum = disc_sum - (CNT_W+1)'(1);
      else                orphan_flush = 1'b1;
    end
    disc_flush = (disc_sum > (CNT_W+1)'(DEPTH)) ? CNT_W'(DEPTH) : disc_sum[CNT_W-1:0];
  end

  // Head-entry presentation; zero when nothing is valid
  always_comb begin
`ifdef LWLR_MERGE_EN
    ext = extend_load(op_q[head_q], addr_q[head_q], rdata_q[head_q], rt_old_q[head_q]);
`else
    ext = extend_load(op_q[head_q], addr_q[head_q], rdata_q[head_q]);
`endif
    bus.out_valid  = out_vld;
    bus.out_wdata  = out_vld ? ext[31:0]      : 32'b0;
    bus.out_rf_wen = out_vld ? ext[35:32]     : 4'b0;
    bus.out_dest   = out_vld ? dest_q[head_q] : '0;
    bus.out_pc     = out_vld ? pc_q[head_q]   : 32'b0;
    bus.pending    = count_q;
    bus.proto_err  = proto_err_q;
  end

  // Control state: pointers, counters, done bits, sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      resp_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
      discard_q   <= '0;
      done_q      <= '0;
      proto_err_q <= 1'b0;
    end else if (bus.flush) begin
      head_q      <= '0;
      resp_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
      discard_q   <= disc_flush;
      done_q      <= '0;
      if (orphan_flush) proto_err_q <= 1'b1;
    end else begin
      if (alloc) begin
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (rsp_fill) begin
        done_q[resp_q] <= 1'b1;
        resp_q         <= resp_q + PTR_W'(1);
      end
      if (retire) head_q <= head_q + PTR_W'(1);
      case ({alloc, retire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      case ({alloc, rsp_fill})
        2'b10:   unfilled_q <= unfilled_q + CNT_W'(1);
        2'b01:   unfilled_q <= unfilled_q - CNT_W'(1);
        default: unfilled_q <= unfilled_q;
      endcase
      if (rsp_discard) discard_q <= discard_q - CNT_W'(1);
      if (rsp_orphan)  proto_err_q <= 1'b1;
    end
  end

  // Entry payload capture at allocation and response data capture at fill
  always_ff @(posedge clk) begin
    if (alloc) begin
      op_q[tail_q]   <= bus.in_op;
      addr_q[tail_q] <= bus.in_low_addr;
      dest_q[tail_q] <= bus.in_dest;
      pc_q[tail_q]   <= bus.in_pc;
`ifdef LWLR_MERGE_EN
      rt_old_q[tail_q] <= bus.in_rt_old;
`endif
    end
    if (rsp_fill) rdata_q[resp_q] <= bus.data_sram_rdata;
  end
endmodule

// File: tb/tb_mem2_load_queue.sv
// Directed testbench for mem2_load_queue (DEPTH=4, DEST_W=5).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_mem2_load_queue;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem2_load_queue_if #(.DEPTH(4), .DEST_W(5)) bus ();

  mem2_load_queue #(.DEPTH(4), .DEST_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 0; bus.in_valid = 0; bus.in_op = 0; bus.in_low_addr = 0;
    bus.in_dest = 0; bus.in_rt_old = 0; bus.in_pc = 0;
    bus.data_sram_data_ok = 0; bus.data_sram_rdata = 0; bus.out_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", bus.pending); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b want 0", bus.proto_err); end
    checks++; if (bus.out_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", bus.out_wdata); end
    checks++; if (bus.out_rf_wen !== 4'h0) begin errors++; $display("FAIL reset_rf_wen got %b want 0000", bus.out_rf_wen); end
    checks++; if (bus.out_dest !== 5'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", bus.out_dest); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.out_pc); end
    reset = 0;
    tick();
  endtask

  // Table of single loads: op, addr, rdata, rt_old and hand-computed results
  logic [2:0]  x_op  [11];
  logic [1:0]  x_a   [11];
  logic [31:0] x_rd  [11];
  logic [31:0] x_exp [11];
  logic [3:0]  x_wen [11];

  task automatic test_extend();
    x_op = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7, 3'd5, 3'd6, 3'd5, 3'd6, 3'd1};
    x_a  = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0};
    x_rd = '{32'h80AB_CDEF, 32'h0000_9A00, 32'h0000_8001, 32'h1234_5678, 32'hCAFE_F00D,
             32'h0123_4567, 32'hAABB_CCDD, 32'hAABB_CCDD, 32'hAABB_CCDD, 32'hAABB_CCDD,
             32'h0000_007F};
`ifdef LWLR_MERGE_EN
    x_exp = '{32'hFFFF_FF80, 32'h0000_009A, 32'hFFFF_8001, 32'h0000_1234, 32'hCAFE_F00D,
              32'h0123_4567, 32'hCCDD_3344, 32'h1122_AABB, 32'hDD22_3344, 32'h1122_33AA,
              32'h0000_007F};
    x_wen = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
`else
    x_exp = '{32'hFFFF_FF80, 32'h0000_009A, 32'hFFFF_8001, 32'h0000_1234, 32'hCAFE_F00D,
              32'h0123_4567, 32'hCCDD_0000, 32'h0000_AABB, 32'hDD00_0000, 32'h0000_00AA,
              32'h0000_007F};
    x_wen = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1100, 4'b0011, 4'b1000, 4'b0001, 4'hF};
`endif
    for (int i = 0; i < 11; i++) begin
      bus.out_ready = 0;
      bus.in_valid = 1; bus.in_op = x_op[i]; bus.in_low_addr = x_a[i];
      bus.in_dest = 5'(i + 1); bus.in_rt_old = 32'h1122_3344; bus.in_pc = 32'h1000 + 32'(i * 4);
      tick();
      bus.in_valid = 0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ext%0d_early_valid got %b want 0", i, bus.out_valid); end
      bus.data_sram_data_ok = 1; bus.data_sram_rdata = x_rd[i];
      tick();
      bus.data_sram_data_ok = 0; bus.data_sram_rdata = 32'h0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ext%0d_valid got %b want 1", i, bus.out_valid); end
      checks++; if (bus.out_wdata !== x_exp[i]) begin errors++; $display("FAIL ext%0d_wdata got %h want %h", i, bus.out_wdata, x_exp[i]); end
      checks++; if (bus.out_rf_wen !== x_wen[i]) begin errors++; $display("FAIL ext%0d_rf_wen got %b want %b", i, bus.out_rf_wen, x_wen[i]); end
      checks++; if (bus.out_dest !== 5'(i + 1)) begin errors++; $display("FAIL ext%0d_dest got %0d want %0d", i, bus.out_dest, i + 1); end
      checks++; if (bus.out_pc !== 32'h1000 + 32'(i * 4)) begin errors++; $display("FAIL ext%0d_pc got %h", i, bus.out_pc); end
      bus.out_ready = 1;
      tick();
      bus.out_ready = 0;
      checks++; if (bus.pending !== 3'd0) begin errors++; $display("FAIL ext%0d_pending got %0d want 0", i, bus.pending); end
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_op = 3'd4; bus.in_low_addr = 2'd2;
    bus.data_sram_rdata = 32'h1234_5678;
    for (int d = 1; d <= 4; d++) begin
      bus.in_dest = 5'(d); bus.in_pc = 32'h40 + 32'(4 * d);
      bus.data_sram_data_ok = (d > 1);
      tick();
    end
    checks++; if (bus.pending !== 3'd4) begin errors++; $display("FAIL b2b_full_pending got %0d want 4", bus.pending); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got %b want 0", bus.in_ready); end
    // last response, plus an allocation attempt that must be refused
    bus.in_dest = 5'd31; bus.data_sram_data_ok = 1;
    tick();
    bus.in_valid = 0; bus.data_sram_data_ok = 0;
    checks++; if (bus.pending !== 3'd4) begin errors++; $display("FAIL b2b_refused_pending got %0d want 4", bus.pending); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", bus.out_valid); end
    tick();
    checks++; if (bus.out_wdata !== 32'h0000_1234 || bus.out_dest !== 5'd1) begin
      errors++; $display("FAIL b2b_stall_hold got %h/%0d want 00001234/1", bus.out_wdata, bus.out_dest); end
    bus.out_ready = 1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_retire_in_ready got %b want 0", bus.in_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out%0d_valid got %b want 1", k, bus.out_valid); end
      checks++; if (bus.out_wdata !== 32'h0000_1234) begin errors++; $display("FAIL b2b_out%0d_wdata got %h want 00001234", k, bus.out_wdata); end
      checks++; if (bus.out_dest !== 5'(k + 1)) begin errors++; $display("FAIL b2b_out%0d_dest got %0d want %0d", k, bus.out_dest, k + 1); end
      checks++; if (bus.out_pc !== 32'h40 + 32'(4 * (k + 1))) begin errors++; $display("FAIL b2b_out%0d_pc got %h", k, bus.out_pc); end
      if (k == 1) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_reopen_in_ready got %b want 1", bus.in_ready); end
        bus.in_valid = 1; bus.in_op = 3'd0; bus.in_low_addr = 2'd0; bus.in_dest = 5'd9; bus.in_pc = 32'h200;
      end
      tick();
      bus.in_valid = 0;
      if (k == 1) begin
        checks++; if (bus.pending !== 3'd3) begin errors++; $display("FAIL b2b_alloc_retire_pending got %0d want 3", bus.pending); end
      end
    end
    checks++; if (bus.pending !== 3'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_unfilled got pending %0d valid %b want 1/0", bus.pending, bus.out_valid); end
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hDEAD_BEEF;
    tick();
    bus.data_sram_data_ok = 0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_lw got valid %b data %h want 1/deadbeef", bus.out_valid, bus.out_wdata); end
    checks++; if (bus.out_dest !== 5'd9 || bus.out_pc !== 32'h200) begin
      errors++; $display("FAIL b2b_lw_tag got %0d/%h want 9/200", bus.out_dest, bus.out_pc); end
    tick();
    bus.out_ready = 0;
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("FAIL b2b_drain got %0d want 0", bus.pending); end
  endtask

  task automatic test_flush();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_op = 3'd0; bus.in_low_addr = 2'd0;
    for (int d = 1; d <= 3; d++) begin
      bus.in_dest = 5'(d); bus.in_pc = 32'h80 + 32'(d);
      tick();
    end
    bus.in_valid = 0;
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h1111_1111;
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b want 1", bus.out_valid); end
    // flush with the second response and an allocation attempt in the same cycle
    bus.flush = 1; bus.data_sram_rdata = 32'h2222_2222;
    bus.in_valid = 1; bus.in_dest = 5'd20;
    tick();
    bus.flush = 0; bus.in_valid = 0; bus.data_sram_data_ok = 0;
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("FAIL flush_pending got %0d want 0", bus.pending); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h3333_3333;
    tick();
    bus.data_sram_data_ok = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL flush_proto_err got %b want 0", bus.proto_err); end
    bus.in_valid = 1; bus.in_op = 3'd0; bus.in_dest = 5'd5; bus.in_pc = 32'h300;
    tick();
    bus.in_valid = 0;
    checks++; if (bus.pending !== 3'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_new_alloc got pending %0d valid %b want 1/0", bus.pending, bus.out_valid); end
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h5A5A_1234;
    tick();
    bus.data_sram_data_ok = 0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'h5A5A_1234) begin
      errors++; $display("FAIL flush_new_data got valid %b data %h want 1/5a5a1234", bus.out_valid, bus.out_wdata); end
    checks++; if (bus.out_dest !== 5'd5 || bus.out_pc !== 32'h300) begin
      errors++; $display("FAIL flush_new_tag got %0d/%h want 5/300", bus.out_dest, bus.out_pc); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL flush_new_proto_err got %b want 0", bus.proto_err); end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    checks++; if (bus.pending !== 3'd0) begin errors++; $display("FAIL flush_drain got %0d want 0", bus.pending); end
  endtask

  task automatic test_proto_err();
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h7777_7777;
    tick();
    bus.data_sram_data_ok = 0;
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL proto_set got %b want 1", bus.proto_err); end
    checks++; if (bus.out_valid !== 1'b0 || bus.pending !== 3'd0) begin
      errors++; $display("FAIL proto_no_output got valid %b pending %0d want 0/0", bus.out_valid, bus.pending); end
    bus.in_valid = 1; bus.in_op = 3'd0; bus.in_dest = 5'd3;
    tick(); tick();
    bus.in_valid = 0;
    checks++; if (bus.proto_err !== 1'b1 || bus.pending !== 3'd2) begin
      errors++; $display("FAIL proto_sticky got err %b pending %0d want 1/2", bus.proto_err, bus.pending); end
    // asynchronous reset between clock edges
    #2 reset = 1;
    #1;
    checks++; if (bus.pending !== 3'd0 || bus.proto_err !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got pending %0d err %b rdy %b want 0/0/1", bus.pending, bus.proto_err, bus.in_ready); end
    tick();
    reset = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_extend();
    test_back_to_back();
    test_flush();
    test_proto_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
